// File: rtl/rs_pkg.sv
// Shared definitions for RS flip-flops and their checkers: invalid-input policies,
// checker state encoding and the reference next-state function.
package rs_pkg;

   localparam int INV_SET  = 0;
   localparam int INV_RST  = 1;
   localparam int INV_HOLD = 2;

   typedef enum logic {
      RUN  = 1'b0,
      FAIL = 1'b1
   } chk_state_t;

   // Next value of an RS flop given its current value; mode selects the S=R=1 outcome.
   function automatic logic rs_next(input logic q, input logic s, input logic r, input int mode);
      logic nxt;
      nxt = q;
      if (s && !r) begin
         nxt = 1'b1;
      end else if (r && !s) begin
         nxt = 1'b0;
      end else if (s && r) begin
         if (mode == INV_SET) begin
            nxt = 1'b1;
         end else if (mode == INV_RST) begin
            nxt = 1'b0;
         end else if (mode == INV_HOLD) begin
            nxt = q;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rs_ff_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/rs_ff_checker.sv
// Monitor for an RS flip-flop: tracks the expected Q one cycle behind the pins,
// flags Q/Qn mismatches and counts compares, mismatches and S=R=1 cycles.
module rs_ff_checker
   import rs_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int INV_MODE = INV_SET
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic             R,
   input  logic             S,
   input  logic             Q,
   input  logic             Qn,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] inv_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] first_err_at,
   output logic             pass
);

   logic             expQ_q;
   logic             expQ_d;
   chk_state_t       state_q;
   chk_state_t       state_d;
   logic [CNT_W-1:0] firstErrAt_q;
   logic [CNT_W-1:0] firstErrAt_d;
   logic             compare;
   logic             mismatch;
   logic             invalid;

   // Case inequality makes an X or Z on the pins count as a mismatch in simulation.
   always_comb begin
      compare  = !rst && chk_en;
      mismatch = (Q !== expQ_q) || (Qn !== ~Q);
      invalid  = !rst && S && R;
      expQ_d   = rs_next(expQ_q, S, R, INV_MODE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expQ_q       <= 1'b0;
         state_q      <= RUN;
         firstErrAt_q <= '0;
      end else begin
         expQ_q       <= expQ_d;
         state_q      <= state_d;
         firstErrAt_q <= firstErrAt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      firstErrAt_d = firstErrAt_q;
      case (state_q)
         RUN: begin
            if (compare && mismatch) begin
               state_d      = FAIL;
               firstErrAt_d = chk_cnt;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_comb begin
      err          = (state_q == FAIL);
      pass         = (chk_cnt != '0) && !err;
      first_err_at = firstErrAt_q;
   end

   sat_counter #(.CNT_W(CNT_W)) uChkCnt (
      .clk (clk),
      .clr (rst),
      .inc (compare),
      .cnt (chk_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uErrCnt (
      .clk (clk),
      .clr (rst),
      .inc (compare && mismatch),
      .cnt (err_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uInvCnt (
      .clk (clk),
      .clr (rst),
      .inc (invalid),
      .cnt (inv_cnt)
   );

endmodule
